tdc_pulse_pair_gen: RTL and testbench

- Synthesizable START/STOP stimulus generator for the TDC. It is clocked by the bench/board master clock and sits directly downstream of the clock generator.
- On a trigger it produces a START pulse, then a STOP pulse whose rising edge comes a programmable number of clock cycles later.
- Provides known time intervals for TDC characterization: linearity sweeps, offset calibration with zero delay, and dead-time checks.
- Outputs drive the TDC start/stop inputs, either directly or via the FPGA pins.

---
 rtl/tdc_pulse_pair_gen_pkg.sv | 19 +
 rtl/tdc_pulse_pair_gen_if.sv | 26 ++
 rtl/tdc_pulse_pair_gen_cycle_counter.sv | 24 ++
 rtl/tdc_pulse_pair_gen.sv | 112 +++++++++++
 tb/tb_tdc_pulse_pair_gen.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/tdc_pulse_pair_gen_pkg.sv
// Shared definitions for the TDC START/STOP pulse-pair generator:
// FSM encoding, default widths and the counter-width helper.
package tdc_stim_pkg;

  localparam int DELAY_W_DEF = 16;
  localparam int PW_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so cnt, D and D+W-1 never wrap for any legal input.
  function automatic int cnt_w(input int delay_w);
    return delay_w + 1;
  endfunction

endpackage

// File: rtl/tdc_pulse_pair_gen_if.sv
// Control/status bundle between a sequencer (master) and the pulse-pair generator (slave).
interface tdc_pulse_pair_gen_if #(
  parameter int DELAY_W = tdc_stim_pkg::DELAY_W_DEF,
  parameter int PW_W    = tdc_stim_pkg::PW_W_DEF
);
  logic               en;
  logic               trig;
  logic [DELAY_W-1:0] delay;
  logic [PW_W-1:0]    width;
  logic               clr_missed;
  logic               start;
  logic               stop;
  logic               busy;
  logic               done;
  logic               missed_trig;

  modport master (
    output en, trig, delay, width, clr_missed,
    input  start, stop, busy, done, missed_trig
  );

  modport slave (
    input  en, trig, delay, width, clr_missed,
    output start, stop, busy, done, missed_trig
  );
endinterface

// File: rtl/tdc_pulse_pair_gen_cycle_counter.sv
// Synchronous up-counter with clear, increment enable and terminal-count compare.
module tdc_cycle_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// TDC START/STOP generator: on a trigger emits START, then STOP a programmed
// number of cycles later; all outputs are registered for direct pin drive.
module tdc_pulse_pair_gen
  import tdc_stim_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int PW_W    = PW_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  tdc_pulse_pair_gen_if.slave   bus
);

  localparam int CNT_W = cnt_w(DELAY_W);

  state_t           state;
  logic [CNT_W-1:0] d_q, w_q, end_q;
  logic [CNT_W-1:0] d_acc, w_acc, end_acc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             tc;
  logic             accept;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    d_acc   = CNT_W'(bus.delay);
    w_acc   = CNT_W'(bus.width);
    if (bus.width == '0) w_acc = CNT_W'(1);
    end_acc = d_acc + w_acc - CNT_W'(1);
  end

  assign accept = (state == IDLE) && bus.en && bus.trig;
  assign cnt_nx = cnt + CNT_W'(1);

  // Counter holds at zero in IDLE so the first RUN cycle sees cnt == 0.
  tdc_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .inc  (state == RUN),
    .term (end_q),
    .cnt  (cnt),
    .tc   (tc)
  );

  // Pulse decode looks at cnt_nx: outputs are registered, so the value loaded
  // at this edge must describe the cycle the counter is about to enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      d_q             <= '0;
      w_q             <= '0;
      end_q           <= '0;
      bus.start       <= 1'b0;
      bus.stop        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.missed_trig <= 1'b0;
    end else begin
      if ((state != IDLE) && bus.trig) bus.missed_trig <= 1'b1;
      else if (bus.clr_missed)         bus.missed_trig <= 1'b0;

      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (accept) begin
            d_q       <= d_acc;
            w_q       <= w_acc;
            end_q     <= end_acc;
            bus.start <= 1'b1;
            bus.stop  <= (d_acc == '0);
            bus.busy  <= 1'b1;
            state     <= RUN;
          end else begin
            bus.start <= 1'b0;
            bus.stop  <= 1'b0;
            bus.busy  <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.en) begin
            bus.start <= 1'b0;
            bus.stop  <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else if (tc) begin
            bus.start <= 1'b0;
            bus.stop  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else begin
            bus.start <= (cnt_nx < w_q);
            bus.stop  <= (cnt_nx >= d_q) && (cnt_nx <= end_q);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.start <= 1'b0;
          bus.stop  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Directed bench for tdc_pulse_pair_gen: reset, interval shapes, snapshot,
// missed-trigger flag, abort, auto-repeat and maximum delay.
module tb_tdc_pulse_pair_gen;

  localparam int DELAY_W = 16;
  localparam int PW_W    = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tdc_pulse_pair_gen_if #(.DELAY_W(DELAY_W), .PW_W(PW_W)) bus ();

  tdc_pulse_pair_gen #(.DELAY_W(DELAY_W), .PW_W(PW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic p,
                            input logic b, input logic d);
    check({tag, ".start"}, bus.start, s);
    check({tag, ".stop"},  bus.stop,  p);
    check({tag, ".busy"},  bus.busy,  b);
    check({tag, ".done"},  bus.done,  d);
  endtask

  // One-cycle trig, then every cycle of the sequence against its interval rule.
  task automatic run_seq(input string tag, input int d, input int w);
    int weff;
    weff = (w == 0) ? 1 : w;
    bus.delay = DELAY_W'(d);
    bus.width = PW_W'(w);
    bus.trig  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    for (int i = 0; i <= d + weff; i++) begin
      check_outs(tag, i < weff, (i >= d) && (i < d + weff), 1'b1, i == d + weff);
      tick();
    end
    check_outs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.trig       = 1'b0;
    bus.delay      = '0;
    bus.width      = '0;
    bus.clr_missed = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.missed", bus.missed_trig, 1'b0);
    rst = 1'b0;

    // trig with en low: ignored, not missed.
    bus.trig = 1'b1;
    tick();
    tick();
    bus.trig = 1'b0;
    check_outs("en_low", 1'b0, 1'b0, 1'b0, 1'b0);
    check("en_low.missed", bus.missed_trig, 1'b0);
    bus.en = 1'b1;

    run_seq("basic_d5w2", 5, 2);
    run_seq("zero_d0w3", 0, 3);
    run_seq("overlap_d1w4", 1, 4);
    run_seq("w0_d3", 3, 0);

    // Snapshot and missed trig: delay changes at k+2, trig again at k+3.
    bus.delay = 16'd5;
    bus.width = 4'd2;
    bus.trig  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_outs("snap", (i <= 2), (i == 6) || (i == 7), 1'b1, i == 8);
      check("snap.missed", bus.missed_trig, i >= 4);
      if (i == 2) bus.delay = 16'd9;
      bus.trig = (i == 3);
      tick();
    end
    bus.trig = 1'b0;
    check_outs("snap.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("snap.missed_sticky", bus.missed_trig, 1'b1);
    bus.clr_missed = 1'b1;
    tick();
    bus.clr_missed = 1'b0;
    check("clr_missed", bus.missed_trig, 1'b0);

    // Set beats clear on the same edge while busy.
    bus.delay = 16'd3;
    bus.width = 4'd1;
    bus.trig  = 1'b1;
    tick();
    bus.clr_missed = 1'b1;
    tick();
    bus.trig       = 1'b0;
    bus.clr_missed = 1'b0;
    check("set_wins", bus.missed_trig, 1'b1);
    repeat (4) tick();
    bus.clr_missed = 1'b1;
    tick();
    bus.clr_missed = 1'b0;
    check("clr_again", bus.missed_trig, 1'b0);

    // Abort: en dropped at edge k+3 during delay=1 width=4.
    bus.delay = 16'd1;
    bus.width = 4'd4;
    bus.trig  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    tick();
    tick();
    check_outs("abort.pre", 1'b1, 1'b1, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    for (int i = 4; i <= 9; i++) begin
      check_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    bus.en = 1'b1;

    // Reset mid-sequence with missed_trig set.
    bus.delay = 16'd10;
    bus.width = 4'd2;
    bus.trig  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    tick();
    bus.trig  = 1'b1;
    tick();
    bus.trig  = 1'b0;
    tick();
    check("rst.pre_missed", bus.missed_trig, 1'b1);
    check("rst.pre_busy", bus.busy, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_mid.missed", bus.missed_trig, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check_outs("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // trig held high: period D+W+2 = 5.
    bus.delay = 16'd2;
    bus.width = 4'd1;
    bus.trig  = 1'b1;
    tick();
    for (int i = 1; i <= 15; i++) begin
      check_outs("repeat", (i % 5) == 1, (i % 5) == 3, (i % 5) != 0, (i % 5) == 4);
      tick();
    end
    bus.trig = 1'b0;
    repeat (6) tick();
    bus.clr_missed = 1'b1;
    tick();
    bus.clr_missed = 1'b0;
    check("repeat.no_missed", bus.missed_trig, 1'b0);

    run_seq("max_delay", 65535, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
